led_step_scheduler: RTL and testbench

//  Sequences the LED colour block (clk, rst, button, colour[2:0]; cycles 1..6, never 0/7).
//  Its button input advances colour once per cycle while high.

---
 rtl/led_pkg.sv | 27 ++
 rtl/btn_debounce.sv | 48 ++++
 rtl/led_step_scheduler.sv | 146 ++++++++++++++
 tb/tb_led_step_scheduler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Purpose: shared colour limits, FSM/source encodings and colour successor for the LED step scheduler.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package led_pkg;

    localparam logic [2:0] COL_MIN = 3'd1;
    localparam logic [2:0] COL_MAX = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STEP   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_FAULT  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_MAN  = 2'b01,
        SRC_AUTO = 2'b10
    } src_e;

    // Colour the LED block shows after one button cycle: 1..6, wrapping 6 -> 1.
    function automatic logic [2:0] next_colour(input logic [2:0] c);
        return (c == COL_MAX) ? COL_MIN : c + 3'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Purpose: 2-flop synchroniser, stable-sample debounce counter and rising-edge pulse for a bouncy button.
// Latency: btn_raw high -> btn_rise high after DEBOUNCE_CYCLES+2 clk edges (sync 2, debounce DEBOUNCE_CYCLES).
// Backpressure: none; btn_rise is a one-cycle pulse the consumer must latch.
// Ports: clk, rst (sync, active-high), btn_raw (async in), btn_rise (one-cycle pulse per debounced press).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          clean_q;
    logic          clean_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= 2'b00;
            cnt_q        <= '0;
            clean_q      <= 1'b0;
            clean_prev_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], btn_raw};
            clean_prev_q <= clean_q;
            // Only an unbroken run of differing samples flips the clean level;
            // a single agreeing sample restarts the run.
            if (sync_q[1] != clean_q) begin
                if (cnt_q == CNT_LAST) begin
                    clean_q <= sync_q[1];
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign btn_rise = clean_q & ~clean_prev_q;

endmodule

// File: rtl/led_step_scheduler.sv
// Purpose: arbitrates manual/auto step requests, pulses the LED block button and checks the colour reply.
// Latency: pending request -> step 1 cycle (IDLE, !hold); btn_raw -> step DEBOUNCE_CYCLES+4 cycles.
// Backpressure: hold freezes grants and the auto timer; one pending bit per source, extra requests dropped.
// Ports: clk, rst (sync, active-high), btn_raw, auto_en, hold, colour_in[2:0] in;
//        step, step_src[1:0], busy, wrap_cnt[WRAP_W-1:0], fault out.
module led_step_scheduler
    import led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AUTO_PERIOD     = 8,
    parameter int WRAP_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_raw,
    input  logic              auto_en,
    input  logic              hold,
    input  logic [2:0]        colour_in,
    output logic              step,
    output logic [1:0]        step_src,
    output logic              busy,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              fault
);

    localparam int TW = $clog2(AUTO_PERIOD);
    localparam logic [TW-1:0] TIMER_LAST = TW'(AUTO_PERIOD - 1);

    state_e            state_q;
    logic              step_q, busy_q, fault_q;
    src_e              src_q;
    logic [2:0]        exp_q;
    logic [WRAP_W-1:0] wrap_q;
    logic [TW-1:0]     timer_q, timer_d;
    logic              man_pend_q, man_pend_d;
    logic              auto_pend_q, auto_pend_d;
    logic              btn_rise, auto_req;
    logic              grant, grant_man, colour_bad;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .btn_rise (btn_rise)
    );

    assign grant      = (state_q == ST_IDLE) && !hold && (man_pend_q || auto_pend_q);
    assign grant_man  = grant && man_pend_q;
    assign colour_bad = (colour_in == 3'd0) || (colour_in == 3'd7);

    always_comb begin
        timer_d  = timer_q;
        auto_req = 1'b0;
        if (!auto_en) begin
            timer_d = '0;
        end else if (!hold && state_q != ST_FAULT) begin
            if (timer_q == TIMER_LAST) begin
                timer_d  = '0;
                auto_req = 1'b1;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    // A granted flag clears even if a fresh request arrives the same cycle:
    // that request found the flag already set and is dropped.
    always_comb begin
        man_pend_d  = man_pend_q;
        auto_pend_d = auto_pend_q;
        if (state_q != ST_FAULT) begin
            man_pend_d  = grant_man ? 1'b0 : (man_pend_q | btn_rise);
            auto_pend_d = (grant && !grant_man) ? 1'b0 : (auto_pend_q | auto_req);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q     <= '0;
            man_pend_q  <= 1'b0;
            auto_pend_q <= 1'b0;
        end else begin
            timer_q     <= timer_d;
            man_pend_q  <= man_pend_d;
            auto_pend_q <= auto_pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            step_q  <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
            src_q   <= SRC_NONE;
            exp_q   <= COL_MIN;
            wrap_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant) begin
                        if (colour_bad) begin
                            state_q <= ST_FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            state_q <= ST_STEP;
                            step_q  <= 1'b1;
                            busy_q  <= 1'b1;
                            exp_q   <= next_colour(colour_in);
                            src_q   <= grant_man ? SRC_MAN : SRC_AUTO;
                        end
                    end
                end
                ST_STEP: begin
                    state_q <= ST_SETTLE;
                    step_q  <= 1'b0;
                end
                ST_SETTLE: begin
                    busy_q <= 1'b0;
                    if (colour_in != exp_q) begin
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        if (exp_q == COL_MIN) begin
                            wrap_q <= wrap_q + WRAP_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_FAULT;
                    step_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    fault_q <= 1'b1;
                end
            endcase
        end
    end

    assign step     = step_q;
    assign step_src = src_q;
    assign busy     = busy_q;
    assign wrap_cnt = wrap_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_led_step_scheduler.sv
// Purpose: scoreboard bench for led_step_scheduler with a behavioural LED colour block.
// Latency: expected step cycles are hand-computed per directed scenario.
// Backpressure: exercised via hold during pending requests.
module tb_led_step_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_raw = 1'b0;
    logic       auto_en = 1'b0;
    logic       hold = 1'b0;
    logic [2:0] colour_in;
    logic       step;
    logic [1:0] step_src;
    logic       busy;
    logic [7:0] wrap_cnt;
    logic       fault;

    // LED block model: advances once per cycle while step is high.
    logic [2:0] led_q;
    logic       freeze = 1'b0;
    logic       force_en = 1'b0;
    logic [2:0] force_val = 3'd0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [1:0] src;
        logic [2:0] col;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    led_step_scheduler #(
        .DEBOUNCE_CYCLES(4),
        .AUTO_PERIOD    (8),
        .WRAP_W         (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .auto_en  (auto_en),
        .hold     (hold),
        .colour_in(colour_in),
        .step     (step),
        .step_src (step_src),
        .busy     (busy),
        .wrap_cnt (wrap_cnt),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst) led_q <= 3'd1;
        else if (step && !freeze) led_q <= (led_q == 3'd6) ? 3'd1 : led_q + 3'd1;
    end

    assign colour_in = force_en ? force_val : led_q;

    // Monitor: every step pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && step === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_step: step=1 at cycle %0d src=%0d, required no step", cyc, step_src);
            end else begin
                mon_e = sb.pop_front();
                if (cyc != mon_e.cyc || step_src !== mon_e.src || colour_in !== mon_e.col) begin
                    errors++;
                    $display("FAIL step_event: got cycle=%0d src=%0d colour=%0d, required cycle=%0d src=%0d colour=%0d",
                             cyc, step_src, colour_in, mon_e.cyc, mon_e.src, mon_e.col);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic go_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic push(input int c, input logic [1:0] s, input logic [2:0] col);
        exp_t e;
        e.cyc = c;
        e.src = s;
        e.col = col;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        btn_raw  = 1'b0;
        auto_en  = 1'b0;
        hold     = 1'b0;
        freeze   = 1'b0;
        force_en = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
    endtask

    logic [2:0] auto_cols [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1, 3'd2};
    int c;

    initial begin
        @(negedge clk);

        // 1: reset state
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("reset_step", {31'd0, step}, 32'd0);
        chk("reset_fault", {31'd0, fault}, 32'd0);
        chk("reset_wrap", {24'd0, wrap_cnt}, 32'd0);
        chk("reset_src", {30'd0, step_src}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        // 2: single manual press, held high
        do_reset();
        c = cyc;
        btn_raw = 1'b1;
        push(c + 8, 2'b01, 3'd1);
        go_to(c + 30);
        chk("man_colour", {29'd0, led_q}, 32'd2);
        chk("man_src", {30'd0, step_src}, 32'd1);
        btn_raw = 1'b0;
        go_to(c + 50);
        chk("man_drained", sb.size(), 32'd0);

        // 3: bounce toggling every 2 cycles must not step
        do_reset();
        for (int i = 0; i < 10; i++) begin
            btn_raw = ~btn_raw;
            repeat (2) @(negedge clk);
        end
        btn_raw = 1'b0;
        repeat (20) @(negedge clk);
        chk("bounce_colour", {29'd0, led_q}, 32'd1);
        chk("bounce_src", {30'd0, step_src}, 32'd0);

        // 4: auto mode for 64 cycles
        do_reset();
        c = cyc;
        auto_en = 1'b1;
        for (int k = 0; k < 8; k++) push(c + 9 + 8 * k, 2'b10, auto_cols[k]);
        go_to(c + 64);
        auto_en = 1'b0;
        go_to(c + 80);
        chk("auto_wrap", {24'd0, wrap_cnt}, 32'd1);
        chk("auto_colour", {29'd0, led_q}, 32'd3);
        chk("auto_src", {30'd0, step_src}, 32'd2);
        chk("auto_drained", sb.size(), 32'd0);

        // 5a: manual and auto pending together
        do_reset();
        c = cyc;
        auto_en = 1'b1;
        go_to(c + 1);
        btn_raw = 1'b1;
        push(c + 9, 2'b01, 3'd1);
        push(c + 12, 2'b10, 3'd2);
        go_to(c + 9);
        auto_en = 1'b0;
        go_to(c + 30);
        chk("both_colour", {29'd0, led_q}, 32'd3);
        chk("both_drained", sb.size(), 32'd0);

        // 5b: same, but hold raised before the grant
        do_reset();
        c = cyc;
        auto_en = 1'b1;
        go_to(c + 1);
        btn_raw = 1'b1;
        go_to(c + 8);
        hold = 1'b1;
        auto_en = 1'b0;
        go_to(c + 12);
        chk("hold_busy", {31'd0, busy}, 32'd0);
        chk("hold_src", {30'd0, step_src}, 32'd0);
        go_to(c + 18);
        push(c + 19, 2'b01, 3'd1);
        push(c + 22, 2'b10, 3'd2);
        hold = 1'b0;
        go_to(c + 40);
        chk("hold_colour", {29'd0, led_q}, 32'd3);
        chk("hold_drained", sb.size(), 32'd0);

        // 6a: LED fails to advance
        do_reset();
        freeze = 1'b1;
        c = cyc;
        btn_raw = 1'b1;
        push(c + 8, 2'b01, 3'd1);
        go_to(c + 9);
        chk("stall_fault_early", {31'd0, fault}, 32'd0);
        go_to(c + 10);
        chk("stall_fault", {31'd0, fault}, 32'd1);
        auto_en = 1'b1;
        go_to(c + 60);
        chk("stall_fault_sticky", {31'd0, fault}, 32'd1);
        chk("stall_busy", {31'd0, busy}, 32'd0);
        chk("stall_drained", sb.size(), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("stall_rst_clears", {31'd0, fault}, 32'd0);

        // 6b: illegal colour 7 at grant
        do_reset();
        force_en = 1'b1;
        force_val = 3'd7;
        c = cyc;
        btn_raw = 1'b1;
        go_to(c + 10);
        chk("illegal_fault", {31'd0, fault}, 32'd1);
        chk("illegal_src", {30'd0, step_src}, 32'd0);
        do_reset();
        chk("illegal_rst_clears", {31'd0, fault}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
